lifting_idwt_1d: RTL and testbench

Inverse 1-D integer lifting wavelet (5/3-style) reconstruction stage for the image squash pipeline. It consumes a line of interleaved low/high coefficient pairs (s[n], d[n]) produced by the forward lifting transform. It emits the reconstructed even/odd pixel pairs (x[2n], x[2n+1]) with valid/ready handshakes on both sides. It is the decoder end of the forward transform and reproduces its 8-bit modular arithmetic exactly.

---
 rtl/lifting_idwt_1d.sv | 109 ++++++++++
 tb/tb_lifting_idwt_1d.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifting_idwt_1d.sv
// Inverse 1-D integer 5/3 lifting stage: rebuilds (x[2n], x[2n+1]) pixel pairs
// from interleaved (s[n], d[n]) coefficients using 8-bit modular arithmetic.
module lifting_idwt_1d #(
    parameter int PAIRS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_low,
    input  logic [7:0] in_high,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_even,
    output logic [7:0] out_odd,
    output logic       out_last
);

    // state | meaning
    // FILL  | waiting for pair 0 of a line; primes x_prev/d_prev, no output
    // RUN   | each accepted pair n emits reconstructed pair n-1
    // FLUSH | emits the final pair using the mirrored right neighbour
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PAIRS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    x_prev;
    logic [7:0]    d_prev;

    logic       slot_free;
    logic       accept;
    logic [7:0] d_left;
    logic [8:0] dsum;
    logic [7:0] xe;
    logic [8:0] xsum;
    logic [7:0] odd_run;

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        in_ready = rst_n && ((state == FILL) || ((state == RUN) && slot_free));
    end

    assign accept = in_valid && in_ready;

    // Pair 0 has no left neighbour, so d[-1] mirrors d[0].
    assign d_left  = (state == FILL) ? in_high : d_prev;
    assign dsum    = {1'b0, d_left} + {1'b0, in_high};
    assign xe      = in_low - {1'b0, dsum[8:2]};
    assign xsum    = {1'b0, x_prev} + {1'b0, xe};
    assign odd_run = d_prev + xsum[8:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            x_prev    <= '0;
            d_prev    <= '0;
            out_valid <= 1'b0;
            out_even  <= '0;
            out_odd   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        x_prev <= xe;
                        d_prev <= in_high;
                        if (PAIRS == 1) begin
                            state <= FLUSH;
                        end else begin
                            state <= RUN;
                            cnt   <= CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_even  <= x_prev;
                        out_odd   <= odd_run;
                        out_last  <= 1'b0;
                        x_prev    <= xe;
                        d_prev    <= in_high;
                        if (cnt == LAST_IDX) state <= FLUSH;
                        else cnt <= cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    // x[2*PAIRS] mirrors x[2*PAIRS-2], so the average collapses to x_prev.
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_even  <= x_prev;
                        out_odd   <= d_prev + x_prev;
                        out_last  <= 1'b1;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_lifting_idwt_1d.sv
// Scoreboard bench for lifting_idwt_1d: three instances (PAIRS = 2, 32, 1) share
// clock and reset; expected pairs are queued at stimulus time and popped by a monitor.
module tb_lifting_idwt_1d;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid [3];
    logic       in_ready [3];
    logic [7:0] in_low   [3];
    logic [7:0] in_high  [3];
    logic       out_valid[3];
    logic       out_ready[3];
    logic [7:0] out_even [3];
    logic [7:0] out_odd  [3];
    logic       out_last [3];

    always #5 clk = ~clk;

    lifting_idwt_1d #(.PAIRS(2)) u_p2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_low(in_low[0]), .in_high(in_high[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_even(out_even[0]),
        .out_odd(out_odd[0]), .out_last(out_last[0])
    );

    lifting_idwt_1d #(.PAIRS(32)) u_p32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_low(in_low[1]), .in_high(in_high[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_even(out_even[1]),
        .out_odd(out_odd[1]), .out_last(out_last[1])
    );

    lifting_idwt_1d #(.PAIRS(1)) u_p1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_low(in_low[2]), .in_high(in_high[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_even(out_even[2]),
        .out_odd(out_odd[2]), .out_last(out_last[2])
    );

    int          vectors = 0;
    int          errors  = 0;
    bit          rnd_en  = 1'b0;
    logic [16:0] sb0[$];
    logic [16:0] sb1[$];
    logic [16:0] sb2[$];
    int          xs[64];
    int          ss[32];
    int          dd[32];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push(input int k, input int e, input int o, input bit l);
        logic [16:0] v;
        v = {e[7:0], o[7:0], l};
        case (k)
            0: sb0.push_back(v);
            1: sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    // Monitor: each pair the DUT hands over must match the oldest expected pair.
    always @(negedge clk) begin : mon
        logic [16:0] e;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                if (sb_size(k) == 0) begin
                    fail($sformatf("unexpected_out_dut%0d", k));
                end else begin
                    case (k)
                        0: e = sb0.pop_front();
                        1: e = sb1.pop_front();
                        default: e = sb2.pop_front();
                    endcase
                    chk($sformatf("out_pair_dut%0d", k),
                        int'({out_even[k], out_odd[k], out_last[k]}), int'(e));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) out_ready[1] = 1'($urandom_range(0, 1));
    end

    task automatic send(input int k, input int s, input int d);
        int b;
        b = 0;
        if (rnd_en) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_low[k]   = s[7:0];
        in_high[k]  = d[7:0];
        in_valid[k] = 1'b1;
        @(negedge clk);
        while (!in_ready[k] && b < 200) begin
            b++;
            @(negedge clk);
        end
        if (b >= 200) fail($sformatf("send_timeout_dut%0d", k));
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
    endtask

    // Reference forward transform, used only to build inputs; expected outputs are xs itself.
    task automatic fwd(input int p);
        int x2, dp;
        for (int n = 0; n < p; n++) begin
            x2 = (n == p - 1) ? xs[2*n] : xs[2*n+2];
            dd[n] = (xs[2*n+1] - ((xs[2*n] + x2) >> 1)) & 255;
        end
        for (int n = 0; n < p; n++) begin
            dp = (n == 0) ? dd[0] : dd[n-1];
            ss[n] = (xs[2*n] + ((dp + dd[n]) >> 2)) & 255;
        end
    endtask

    task automatic run_line(input int k, input int p, input int stall_at, input int rst_at);
        fwd(p);
        for (int n = 0; n < p; n++) begin
            if (n == rst_at) begin
                out_ready[k] = 1'b0;
                if (k == 1) void'(sb1.pop_back());
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_out_valid", int'(out_valid[k]), 0);
                chk("rst_in_ready_low", int'(in_ready[k]), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                out_ready[k] = 1'b1;
                @(negedge clk);
                chk("post_rst_in_ready", int'(in_ready[k]), 1);
                @(posedge clk);
                #1;
                return;
            end
            if (n == stall_at) begin
                out_ready[k] = 1'b0;
                in_low[k]    = ss[n][7:0];
                in_high[k]   = dd[n][7:0];
                in_valid[k]  = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready[k]), 0);
                    chk("stall_out_held", int'({out_valid[k], out_even[k], out_odd[k], out_last[k]}),
                        int'({1'b1, 8'(xs[2*n-4]), 8'(xs[2*n-3]), 1'b0}));
                end
                @(posedge clk);
                #1 out_ready[k] = 1'b1;
            end
            if (n > 0) push(k, xs[2*n-2], xs[2*n-1], 1'b0);
            send(k, ss[n], dd[n]);
        end
        push(k, xs[2*p-2], xs[2*p-1], 1'b1);
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((sb0.size() + sb1.size() + sb2.size()) != 0 && b < 300) begin
            b++;
            @(negedge clk);
        end
        chk(name, sb0.size() + sb1.size() + sb2.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_low[k]    = '0;
            in_high[k]   = '0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("in_ready_in_reset_dut%0d", k), int'(in_ready[k]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_outputs_dut%0d", k),
                int'({out_valid[k], out_even[k], out_odd[k], out_last[k]}), 0);
            chk($sformatf("in_ready_after_reset_dut%0d", k), int'(in_ready[k]), 1);
        end
        @(posedge clk);
        #1;

        // PAIRS=2 hand-computed line, including last-pair timing.
        send(0, 252, 215);
        push(0, 145, 56, 1'b0);
        send(0, 112, 40);
        push(0, 49, 89, 1'b1);
        @(negedge clk);
        chk("p2_first_out", int'({out_valid[0], out_last[0]}), 2);
        @(negedge clk);
        chk("p2_last_out", int'({out_valid[0], out_last[0]}), 3);
        @(posedge clk);
        #1;

        // PAIRS=1: x0 = 100 - 10 = 90, x1 = 20 + 90 = 110.
        send(2, 100, 20);
        push(2, 90, 110, 1'b1);
        drain("drain_directed");

        // Round trip with 0/255 wrap neighbours and a 5-cycle output stall.
        for (int i = 0; i < 64; i++) xs[i] = (i < 10) ? ((i % 2 == 1) ? 255 : 0) : ((i * 37 + 11) % 256);
        xs[40] = 255; xs[41] = 0; xs[42] = 255;
        run_line(1, 32, 11, -1);
        drain("drain_roundtrip");

        // Reset after pair 10, then a fresh line must reconstruct.
        for (int i = 0; i < 64; i++) xs[i] = (i * 91 + 200) % 256;
        run_line(1, 32, -1, 11);
        for (int i = 0; i < 64; i++) xs[i] = 255 - ((i * 13) % 256);
        run_line(1, 32, -1, -1);
        drain("drain_after_reset");

        // Three back-to-back random lines under random gaps and backpressure.
        rnd_en = 1'b1;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 64; i++) xs[i] = $urandom_range(0, 255);
            if (l == 1) begin xs[0] = 0; xs[1] = 255; xs[2] = 0; xs[63] = 255; end
            run_line(1, 32, -1, -1);
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #1 out_ready[1] = 1'b1;
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
